// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the instruction cache controller states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache's own view; master is the datapath/memory side.
interface instr_cache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  flush;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  iwait;

    modport slave (
        input  imemREN, imemaddr, flush, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. Hits are combinational; a miss
// fills the whole line word by word from memory before the fetch can hit.
module instr_cache #(
    parameter int SETS     = 16,
    parameter int BLKWORDS = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    instr_cache_if.slave  cif
);
    import cpu_types_pkg::*;

    localparam int OFF_BITS = $clog2(BLKWORDS);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = 32 - 2 - OFF_BITS - IDX_W;
    localparam int CNT_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLKWORDS - 1);

    icache_state_t    state;
    icache_state_t    next_state;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_arr  [SETS];
    word_t            data_arr [SETS][BLKWORDS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [CNT_W-1:0] req_off;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             abort;

    logic             lookup_hit;
    logic             start_fill;
    logic             beat;
    logic             fill_done;
    logic             ihit;
    word_t            imemload;
    logic             iren;
    word_t            iaddr;

    assign req_off = CNT_W'((cif.imemaddr >> 2) & 32'(BLKWORDS - 1));
    assign req_idx = IDX_W'(cif.imemaddr >> (2 + OFF_BITS));
    assign req_tag = TAG_W'(cif.imemaddr >> (2 + OFF_BITS + IDX_W));

    assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);

    // A flush cycle counts as a miss, so a request held through it starts a fill.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iren       = 1'b0;
        iaddr      = '0;
        start_fill = 1'b0;
        beat       = 1'b0;
        fill_done  = 1'b0;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (cif.imemREN) begin
                    if (lookup_hit && !cif.flush) begin
                        ihit     = 1'b1;
                        imemload = data_arr[req_idx][req_off];
                    end else begin
                        start_fill = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                iren  = 1'b1;
                iaddr = {fill_tag, fill_idx, {(OFF_BITS + 2){1'b0}}} | (32'(cnt) << 2);
                if (!cif.iwait) begin
                    beat     = 1'b1;
                    cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        fill_done  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Flush always beats a completing fill; an aborted fill never sets valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            valid    <= '0;
            cnt      <= '0;
            abort    <= 1'b0;
            fill_tag <= '0;
            fill_idx <= '0;
        end else begin
            state <= next_state;
            if (start_fill) begin
                fill_tag <= req_tag;
                fill_idx <= req_idx;
                cnt      <= '0;
            end else begin
                cnt <= cnt_next;
            end
            if (fill_done) begin
                abort <= 1'b0;
            end else if (state == FILL && cif.flush) begin
                abort <= 1'b1;
            end
            if (cif.flush) begin
                valid <= '0;
            end else if (fill_done && !abort) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (beat) begin
            data_arr[fill_idx][cnt] <= cif.iload;
        end
        if (fill_done) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

    assign cif.ihit     = ihit;
    assign cif.imemload = imemload;
    assign cif.iREN     = iren;
    assign cif.iaddr    = iaddr;

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus random fetches
// against a per-set block-residency model and a deterministic memory.
module tb_instr_cache;
    import cpu_types_pkg::*;

    localparam int SETS      = 8;
    localparam int BLKWORDS  = 2;
    localparam int BLK_SHIFT = 3;
    localparam int TIMEOUT   = 200;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    instr_cache_if cif();

    instr_cache #(.SETS(SETS), .BLKWORDS(BLKWORDS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .cif  (cif)
    );

    always #5 CLK = ~CLK;

    // Memory: every beat waits wait_n cycles; content is a fixed function of the address.
    int          wait_n = 1;
    int          wcnt   = 0;
    logic [31:0] beat_q [$];

    function automatic word_t mem_word(input logic [31:0] a);
        return 32'hDEAD0000 + (a >> 2) - 32'd15;
    endfunction

    assign cif.iload = mem_word(cif.iaddr);
    assign cif.iwait = (wcnt < wait_n);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt <= 0;
        end else if (cif.iREN) begin
            if (!cif.iwait) begin
                wcnt <= 0;
                beat_q.push_back(cif.iaddr);
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    bit          ref_valid [SETS];
    logic [31:0] ref_blk   [SETS];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> BLK_SHIFT) % SETS);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[idx_of(a)] && (ref_blk[idx_of(a)] == (a >> BLK_SHIFT));
    endfunction

    task automatic ref_fill(input logic [31:0] a);
        ref_valid[idx_of(a)] = 1'b1;
        ref_blk[idx_of(a)]   = a >> BLK_SHIFT;
    endtask

    task automatic ref_flush();
        for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
    endtask

    function automatic int miss_cycles(input int w);
        return 1 + BLKWORDS * (w + 1);
    endfunction

    // Holds a request until it hits; reports cycles spent before the hit.
    task automatic fetch(input logic [31:0] a, output int cycles, output word_t data,
                         output logic ren_hit, output logic ren1, output logic [31:0] addr1,
                         output logic stray);
        cif.imemREN  = 1'b1;
        cif.imemaddr = a;
        cycles = 0; data = '0; ren_hit = 1'b0; ren1 = 1'b0; addr1 = '0; stray = 1'b0;
        forever begin
            @(negedge CLK);
            if (cycles == 1) begin
                ren1  = cif.iREN;
                addr1 = cif.iaddr;
            end
            if (cif.ihit) begin
                data    = cif.imemload;
                ren_hit = cif.iREN;
                break;
            end
            if (cif.imemload !== 32'h0) stray = 1'b1;
            cycles++;
            if (cycles >= TIMEOUT) begin
                total++; bad++;
                $display("[TB] FAIL fetch_timeout: addr=%h no hit after %0d cycles, want hit", a, cycles);
                break;
            end
        end
        @(posedge CLK);
        #1;
        cif.imemREN = 1'b0;
    endtask

    task automatic test_reset();
        cif.imemREN = 1'b1; cif.imemaddr = 32'h40; cif.flush = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++; if (cif.ihit !== 1'b0) begin bad++; $display("[TB] FAIL reset_ihit: got %b want 0", cif.ihit); end
        total++; if (cif.iREN !== 1'b0) begin bad++; $display("[TB] FAIL reset_iREN: got %b want 0", cif.iREN); end
        total++; if (cif.iaddr !== 32'h0) begin bad++; $display("[TB] FAIL reset_iaddr: got %h want 0", cif.iaddr); end
        total++; if (cif.imemload !== 32'h0) begin bad++; $display("[TB] FAIL reset_imemload: got %h want 0", cif.imemload); end
        @(posedge CLK); #1;
        nRST = 1'b1; cif.imemREN = 1'b0;
        ref_flush();
        @(posedge CLK); #1;
    endtask

    task automatic test_cold_fill();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        wait_n = 1; beat_q.delete();
        fetch(32'h40, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL cold_latency: got %0d want 5", cyc); end
        total++; if (d !== 32'hDEAD0001) begin bad++; $display("[TB] FAIL cold_data: got %h want DEAD0001", d); end
        total++; if (beat_q.size() !== 2) begin bad++; $display("[TB] FAIL cold_beats: got %0d want 2", beat_q.size()); end
        else begin
            total++; if (beat_q[0] !== 32'h40) begin bad++; $display("[TB] FAIL cold_addr0: got %h want 40", beat_q[0]); end
            total++; if (beat_q[1] !== 32'h44) begin bad++; $display("[TB] FAIL cold_addr1: got %h want 44", beat_q[1]); end
        end
        total++; if (r1 !== 1'b1 || a1 !== 32'h40) begin bad++; $display("[TB] FAIL cold_first_req: got iREN=%b iaddr=%h want 1/40", r1, a1); end
        total++; if (st !== 1'b0) begin bad++; $display("[TB] FAIL cold_miss_load: got nonzero imemload while ihit=0, want 0"); end
        ref_fill(32'h40);
    endtask

    task automatic test_hit();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        fetch(32'h44, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 0) begin bad++; $display("[TB] FAIL hit_latency: got %0d want 0", cyc); end
        total++; if (d !== 32'hDEAD0002) begin bad++; $display("[TB] FAIL hit_data: got %h want DEAD0002", d); end
        total++; if (rh !== 1'b0) begin bad++; $display("[TB] FAIL hit_iREN: got %b want 0", rh); end
    endtask

    task automatic test_conflict();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        beat_q.delete();
        fetch(32'h240, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL conflict_latency: got %0d want 5", cyc); end
        total++; if (d !== mem_word(32'h240)) begin bad++; $display("[TB] FAIL conflict_data: got %h want %h", d, mem_word(32'h240)); end
        total++; if (beat_q.size() !== 2 || beat_q[0] !== 32'h240 || beat_q[$] !== 32'h244) begin
            bad++; $display("[TB] FAIL conflict_beats: got n=%0d, want 240/244", beat_q.size());
        end
        ref_fill(32'h240);
        fetch(32'h40, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL conflict_evicted: got %0d want 5", cyc); end
        ref_fill(32'h40);
    endtask

    task automatic test_flush();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        fetch(32'h48, cyc, d, rh, r1, a1, st);
        ref_fill(32'h48);
        cif.flush = 1'b1; cif.imemREN = 1'b1; cif.imemaddr = 32'h40;
        @(negedge CLK);
        total++; if (cif.ihit !== 1'b0) begin bad++; $display("[TB] FAIL flush_force_ihit: got %b want 0", cif.ihit); end
        @(posedge CLK); #1;
        cif.flush = 1'b0;
        ref_flush();
        fetch(32'h40, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== BLKWORDS * (wait_n + 1)) begin bad++; $display("[TB] FAIL flush_req_fill: got %0d want %0d", cyc, BLKWORDS * (wait_n + 1)); end
        ref_fill(32'h40);
        fetch(32'h48, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL flush_other_set: got %0d want 5", cyc); end
        ref_fill(32'h48);
        cif.flush = 1'b1;
        @(posedge CLK); #1;
        cif.flush = 1'b0;
        ref_flush();
        fetch(32'h40, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL flush_refetch: got %0d want 5", cyc); end
        total++; if (r1 !== 1'b1) begin bad++; $display("[TB] FAIL flush_iREN_next: got %b want 1", r1); end
        ref_fill(32'h40);
    endtask

    task automatic test_flush_during_fill();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        logic [31:0] addrs [2];
        int flush_at [2];
        addrs[0] = 32'h80; addrs[1] = 32'hC0;
        flush_at[0] = 3; flush_at[1] = 4;
        wait_n = 1;
        for (int k = 0; k < 2; k++) begin
            beat_q.delete();
            fork
                fetch(addrs[k], cyc, d, rh, r1, a1, st);
                begin
                    repeat (flush_at[k]) @(posedge CLK);
                    #1 cif.flush = 1'b1;
                    @(posedge CLK);
                    #1 cif.flush = 1'b0;
                end
            join
            total++; if (cyc !== 2 * BLKWORDS * (wait_n + 1) + 2) begin
                bad++; $display("[TB] FAIL abort_latency[%0d]: got %0d want %0d", k, cyc, 2 * BLKWORDS * (wait_n + 1) + 2);
            end
            total++; if (beat_q.size() !== 2 * BLKWORDS) begin bad++; $display("[TB] FAIL abort_beats[%0d]: got %0d want %0d", k, beat_q.size(), 2 * BLKWORDS); end
            total++; if (d !== mem_word(addrs[k])) begin bad++; $display("[TB] FAIL abort_data[%0d]: got %h want %h", k, d, mem_word(addrs[k])); end
            ref_flush();
            ref_fill(addrs[k]);
            fetch(addrs[k], cyc, d, rh, r1, a1, st);
            total++; if (cyc !== 0) begin bad++; $display("[TB] FAIL abort_refilled[%0d]: got %0d want 0", k, cyc); end
        end
    endtask

    task automatic test_fill_no_abort();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        wait_n = 1; beat_q.delete();
        cif.imemREN = 1'b1; cif.imemaddr = 32'h100;
        @(posedge CLK); #1;
        cif.imemREN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cif.imemaddr = $urandom;
            @(posedge CLK); #1;
        end
        total++; if (beat_q.size() !== 2 || beat_q[0] !== 32'h100) begin bad++; $display("[TB] FAIL noabort_beats: got n=%0d, want 2 from 100", beat_q.size()); end
        ref_fill(32'h100);
        fetch(32'h104, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 0) begin bad++; $display("[TB] FAIL noabort_hit: got %0d want 0", cyc); end
        total++; if (d !== mem_word(32'h104)) begin bad++; $display("[TB] FAIL noabort_data: got %h want %h", d, mem_word(32'h104)); end
    endtask

    task automatic test_reset_mid_fill();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        int want;
        wait_n = 1;
        want = ref_hit(32'h40) ? 0 : miss_cycles(wait_n);
        fetch(32'h40, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== want) begin bad++; $display("[TB] FAIL rst_prefill: got %0d want %0d", cyc, want); end
        ref_fill(32'h40);
        cif.imemREN = 1'b1; cif.imemaddr = 32'h88;
        @(posedge CLK); #1;
        @(negedge CLK);
        total++; if (cif.iREN !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_fill: got %b want 1", cif.iREN); end
        #1 nRST = 1'b0;
        #1;
        total++; if (cif.iREN !== 1'b0 || cif.iaddr !== 32'h0) begin
            bad++; $display("[TB] FAIL rst_async_drop: got iREN=%b iaddr=%h want 0/0", cif.iREN, cif.iaddr);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        ref_flush();
        fetch(32'h40, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL rst_after_miss: got %0d want 5", cyc); end
        ref_fill(32'h40);
        fetch(32'h88, cyc, d, rh, r1, a1, st);
        total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL rst_no_validate: got %0d want 5", cyc); end
        ref_fill(32'h88);
    endtask

    task automatic test_random();
        int cyc; word_t d; logic rh, r1, st; logic [31:0] a1;
        logic [31:0] a;
        bit exp_hit;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                cif.flush = 1'b1;
                @(posedge CLK); #1;
                cif.flush = 1'b0;
                ref_flush();
            end
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, SETS - 1)) << 3)
              | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            wait_n  = $urandom_range(0, 2);
            exp_hit = ref_hit(a);
            beat_q.delete();
            fetch(a, cyc, d, rh, r1, a1, st);
            total++; if (cyc !== (exp_hit ? 0 : miss_cycles(wait_n))) begin
                bad++; $display("[TB] FAIL rand_latency: addr=%h got %0d want %0d", a, cyc, exp_hit ? 0 : miss_cycles(wait_n));
            end
            total++; if (d !== mem_word(a)) begin bad++; $display("[TB] FAIL rand_data: addr=%h got %h want %h", a, d, mem_word(a)); end
            total++; if (st !== 1'b0) begin bad++; $display("[TB] FAIL rand_miss_load: addr=%h got nonzero imemload while ihit=0, want 0", a); end
            if (!exp_hit) begin
                total++; if (beat_q.size() !== BLKWORDS || beat_q[0] !== (a & ~32'h7)) begin
                    bad++; $display("[TB] FAIL rand_beats: addr=%h got n=%0d, want %0d from %h", a, beat_q.size(), BLKWORDS, a & ~32'h7);
                end
                ref_fill(a);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_cold_fill();
        test_hit();
        test_conflict();
        test_flush();
        test_flush_during_fill();
        test_fill_no_abort();
        test_reset_mid_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
